countdown_timer: RTL

Bomb countdown timer: the consumer of the game FSM's `begin_timer` and `enable` outputs, and the producer of the `ascii_timer` digits shown on the playing screen and of the `time_up` level that drives the game-lost path. It loads a preset time on `begin_timer` and counts down one second per `CLK_HZ` clock cycles while `enable` is high. On each strike it subtracts a fixed penalty. At 0:00 it raises `time_up` and holds it.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/sec_to_ascii.sv | 24 ++
 rtl/countdown_timer.sv | 98 +++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the bomb countdown timer and its display path.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam int         MAX_SECONDS = 599;

  // Binary seconds (0..599) to {minutes, seconds-tens, seconds-ones} ASCII.
  function automatic logic [23:0] seconds_to_ascii(input logic [9:0] secs);
    logic [9:0] sec_of_min;
    logic [7:0] d_min;
    logic [7:0] d_tens;
    logic [7:0] d_ones;
    sec_of_min = secs % 10'd60;
    d_min      = 8'(secs / 10'd60);
    d_tens     = 8'(sec_of_min / 10'd10);
    d_ones     = 8'(sec_of_min % 10'd10);
    return {ASCII_ZERO | d_min, ASCII_ZERO | d_tens, ASCII_ZERO | d_ones};
  endfunction

endpackage

// File: rtl/sec_to_ascii.sv
// Registered seconds-to-ASCII converter with one cycle of latency.
// RESET_SECONDS sets what the display shows while reset is asserted.
module sec_to_ascii
  import timer_pkg::*;
#(
  parameter logic [9:0] RESET_SECONDS = 10'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [9:0]  seconds_i,
  output logic [23:0] ascii_o
);

  logic [23:0] ascii_q;

  // Register the converted digits every cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ascii_q <= seconds_to_ascii(RESET_SECONDS);
    else          ascii_q <= seconds_to_ascii(seconds_i);
  end

  assign ascii_o = ascii_q;

endmodule

// File: rtl/countdown_timer.sv
// Bomb countdown timer: loads a preset on begin_timer, counts down one second
// every CLK_HZ enabled cycles, subtracts a penalty per strike and latches
// time_up at 0:00 until the next begin_timer or reset.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ      = 65_000_000,
  parameter int START_MIN   = 5,
  parameter int START_SEC   = 0,
  parameter int PENALTY_SEC = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        begin_timer,
  input  logic        enable,
  input  logic        strike,
  output logic [23:0] ascii_timer,
  output logic        time_up,
  output logic        running,
  output logic        tick
);

  localparam int              PS_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_HZ - 1);
  localparam logic [9:0]      PRESET = 10'(START_MIN * 60 + START_SEC);
  localparam logic [10:0]     PEN    = 11'(PENALTY_SEC);

  state_e          state_q, state_d;
  logic [9:0]      remaining_q, remaining_d;
  logic [PS_W-1:0] prescale_q, prescale_d;
  logic            tick_q, tick_d;
  logic            running_q, time_up_q;
  logic            wrap;
  logic [10:0]     sub;

  // Next-state logic: begin_timer wins over counting, strikes and ticks.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    prescale_d  = prescale_q;
    tick_d      = 1'b0;
    wrap        = 1'b0;
    sub         = 11'd0;
    if (begin_timer) begin
      remaining_d = PRESET;
      prescale_d  = '0;
      state_d     = RUNNING;
    end else if (state_q == RUNNING && enable) begin
      if (prescale_q == PS_MAX) begin
        prescale_d = '0;
        wrap       = 1'b1;
      end else begin
        prescale_d = prescale_q + PS_W'(1);
      end
      // A strike landing on a second boundary removes PENALTY_SEC+1 at once.
      sub = (strike ? PEN : 11'd0) + (wrap ? 11'd1 : 11'd0);
      if (sub != 11'd0) begin
        remaining_d = ({1'b0, remaining_q} > sub) ? 10'({1'b0, remaining_q} - sub) : 10'd0;
        if (remaining_d == 10'd0) state_d = EXPIRED;
      end
      tick_d = wrap;
    end
  end

  // State, counters and status flags; flags follow the next state so they
  // change on the same edge as the FSM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= PRESET;
      prescale_q  <= '0;
      tick_q      <= 1'b0;
      running_q   <= 1'b0;
      time_up_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      prescale_q  <= prescale_d;
      tick_q      <= tick_d;
      running_q   <= (state_d == RUNNING);
      time_up_q   <= (state_d == EXPIRED);
    end
  end

  sec_to_ascii #(
    .RESET_SECONDS(PRESET)
  ) u_disp (
    .clock    (clock),
    .reset_n  (reset_n),
    .seconds_i(remaining_q),
    .ascii_o  (ascii_timer)
  );

  assign tick    = tick_q;
  assign running = running_q;
  assign time_up = time_up_q;

endmodule
